// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared types and defaults for the memory interface unit
package mem_if_pkg;

    localparam int ADDR_W_DEF    = 14;
    localparam int WR_W_DEF      = 16;
    localparam int RD_W_DEF      = 8;
    localparam int TIMEOUT_DEF   = 16;
    localparam int MAX_RETRY_DEF = 2;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        BACKOFF
    } state_e;

    typedef enum logic {
        OP_LOAD,
        OP_STORE
    } op_e;

    // Counter width able to hold 0..n, kept at least one bit so a disabled feature still elaborates.
    function automatic int cnt_w(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/mem_if_timer.sv
// rtl/mem_if_timer.sv - per-attempt response timer and retry counter
module mem_if_timer
    import mem_if_pkg::*;
#(
    parameter int TIMEOUT   = TIMEOUT_DEF,
    parameter int MAX_RETRY = MAX_RETRY_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tmr_clear_i,
    input  logic tmr_inc_i,
    input  logic rty_clear_i,
    input  logic rty_inc_i,
    output logic expired_o,
    output logic retry_left_o
);

    localparam int TW = cnt_w(TIMEOUT);
    localparam int RW = cnt_w(MAX_RETRY);
    localparam logic [TW-1:0] TMR_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [RW-1:0] RTY_MAX  = RW'(MAX_RETRY);
    localparam logic          TMR_EN   = (TIMEOUT > 0);

    logic [TW-1:0] tmr_q, tmr_d;
    logic [RW-1:0] rty_q, rty_d;

    // Both counters saturate rather than wrap; the FSM leaves REQ before the timer could pass its last value.
    always_comb begin
        tmr_d = tmr_q;
        if (tmr_clear_i) begin
            tmr_d = '0;
        end else if (tmr_inc_i && (tmr_q != TMR_LAST)) begin
            tmr_d = tmr_q + TW'(1);
        end

        rty_d = rty_q;
        if (rty_clear_i) begin
            rty_d = '0;
        end else if (rty_inc_i && (rty_q != RTY_MAX)) begin
            rty_d = rty_q + RW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tmr_q <= '0;
            rty_q <= '0;
        end else begin
            tmr_q <= tmr_d;
            rty_q <= rty_d;
        end
    end

    assign expired_o    = TMR_EN && (tmr_q == TMR_LAST);
    assign retry_left_o = (rty_q < RTY_MAX);

endmodule

// File: rtl/mem_if_ctrl.sv
// rtl/mem_if_ctrl.sv - load/store command unit towards the MSS with timeout, retry and error pulse
module mem_if_ctrl
    import mem_if_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int WR_W      = WR_W_DEF,
    parameter int RD_W      = RD_W_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF,
    parameter int MAX_RETRY = MAX_RETRY_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              store,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WR_W-1:0]   result,
    output logic              cmd_ready,
    output logic              mem_done,
    output logic              mem_err,
    output logic [RD_W-1:0]   datatoinst,
    output logic              read_req,
    output logic              write_req,
    output logic [ADDR_W-1:0] addrout,
    output logic [WR_W-1:0]   datatomem,
    input  logic [RD_W-1:0]   datafrommem,
    input  logic              mem_resp
);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WR_W-1:0]   wdata_q, wdata_d;
    logic [RD_W-1:0]   rdata_q, rdata_d;

    logic tmr_clear, tmr_inc, rty_clear, rty_inc;
    logic expired, retry_left;

    mem_if_timer #(
        .TIMEOUT   (TIMEOUT),
        .MAX_RETRY (MAX_RETRY)
    ) u_timer (
        .clk          (clk),
        .reset_n      (reset_n),
        .tmr_clear_i  (tmr_clear),
        .tmr_inc_i    (tmr_inc),
        .rty_clear_i  (rty_clear),
        .rty_inc_i    (rty_inc),
        .expired_o    (expired),
        .retry_left_o (retry_left)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        tmr_clear = 1'b1;
        tmr_inc   = 1'b0;
        rty_clear = 1'b0;
        rty_inc   = 1'b0;

        unique case (state_q)
            IDLE: begin
                rty_clear = 1'b1;
                // A simultaneous load is dropped: the store owns the transaction.
                if (store) begin
                    op_d    = OP_STORE;
                    wr_d    = 1'b1;
                    addr_d  = addr;
                    wdata_d = result;
                    state_d = REQ;
                end else if (load) begin
                    op_d    = OP_LOAD;
                    rd_d    = 1'b1;
                    addr_d  = addr;
                    state_d = REQ;
                end
            end

            REQ: begin
                tmr_clear = 1'b0;
                tmr_inc   = 1'b1;
                // The response takes priority over a timeout landing in the same cycle.
                if (mem_resp) begin
                    rd_d      = 1'b0;
                    wr_d      = 1'b0;
                    done_d    = 1'b1;
                    tmr_clear = 1'b1;
                    rty_clear = 1'b1;
                    state_d   = IDLE;
                    if (op_q == OP_LOAD) begin
                        rdata_d = datafrommem;
                    end
                end else if (expired) begin
                    rd_d      = 1'b0;
                    wr_d      = 1'b0;
                    tmr_clear = 1'b1;
                    if (retry_left) begin
                        rty_inc = 1'b1;
                        state_d = BACKOFF;
                    end else begin
                        err_d     = 1'b1;
                        rty_clear = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end

            BACKOFF: begin
                rd_d    = (op_q == OP_LOAD);
                wr_d    = (op_q == OP_STORE);
                state_d = REQ;
            end

            default: begin
                rd_d    = 1'b0;
                wr_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            op_q    <= OP_LOAD;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign cmd_ready  = (state_q == IDLE);
    assign mem_done   = done_q;
    assign mem_err    = err_q;
    assign datatoinst = rdata_q;
    assign read_req   = rd_q;
    assign write_req  = wr_q;
    assign addrout    = addr_q;
    assign datatomem  = wdata_q;

endmodule
